// File: rtl/agni_sm_pkg.sv
// agni_sm_pkg: shared SM issue types and widths.
package agni_sm_pkg;
  localparam int OPCODE_W = 6;
  typedef enum logic {IDLE, ISSUE} issue_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after last+1, with wrap-around.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  logic [W-1:0] c;
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant = '0;
    idx = '0;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = last + W'(i);
      if (req[c]) begin
        grant = '0;
        grant[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/warp_issue_sequencer.sv
// warp_issue_sequencer: round-robin warp issue with per-beat thread replay; watchdog under DISPATCH_WATCHDOG_EN.
module warp_issue_sequencer import agni_sm_pkg::*; #(
  parameter int NUM_WARPS      = 8,
  parameter int NUM_THREADS    = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_WARPS-1:0]             warp_req,
  input  logic [NUM_WARPS*NUM_THREADS-1:0] warp_mask,
  input  logic [NUM_WARPS*OPCODE_W-1:0]    warp_opcode,
  input  logic [NUM_WARPS-1:0]             warp_is_fp,
  input  logic [NUM_THREADS-1:0]           core_ready,
  input  logic                             flush,
  output logic [NUM_WARPS-1:0]             warp_grant,
  output logic                             disp_warp_valid,
  output logic [NUM_THREADS-1:0]           disp_thread_active,
  output logic [OPCODE_W-1:0]              disp_opcode,
  output logic                             disp_is_fp,
  output logic [$clog2(NUM_WARPS)-1:0]     disp_warp_id,
  output logic                             issue_done,
  output logic [$clog2(NUM_WARPS)-1:0]     issue_done_id,
  output logic                             busy,
  output logic                             stall_timeout
);
  localparam int IW = $clog2(NUM_WARPS);
  issue_state_e state;
  logic [NUM_THREADS-1:0] pending, next_pending, sel_mask;
  logic [OPCODE_W-1:0] op_q;
  logic fp_q, in_issue, grant_fire;
  logic [IW-1:0] id_q, last_grant, arb_idx;
  logic [NUM_WARPS-1:0] arb_grant;
  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req(warp_req), .last(last_grant), .grant(arb_grant), .idx(arb_idx)
  );
  assign in_issue = state == ISSUE;
  assign grant_fire = rst_n && !in_issue && !flush && |warp_req;
  assign sel_mask = warp_mask[arb_idx*NUM_THREADS +: NUM_THREADS];
  assign next_pending = pending & ~core_ready;
  assign warp_grant = grant_fire ? arb_grant : '0;
  assign issue_done = in_issue ? !flush && next_pending == '0 : grant_fire && sel_mask == '0;
  assign issue_done_id = !issue_done ? '0 : in_issue ? id_q : arb_idx;
  assign disp_warp_valid = in_issue;
  assign busy = in_issue;
  assign disp_thread_active = pending;
  assign disp_opcode = op_q;
  assign disp_is_fp = fp_q;
  assign disp_warp_id = id_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      op_q <= '0;
      fp_q <= 1'b0;
      id_q <= '0;
      last_grant <= IW'(NUM_WARPS - 1);
    end else if (!in_issue) begin
      if (grant_fire) begin
        last_grant <= arb_idx;
        id_q <= arb_idx;
        pending <= sel_mask;
        op_q <= warp_opcode[arb_idx*OPCODE_W +: OPCODE_W];
        fp_q <= warp_is_fp[arb_idx];
        state <= sel_mask != '0 ? ISSUE : IDLE;
      end
    end else begin
      pending <= flush ? '0 : next_pending;
      state <= flush || next_pending == '0 ? IDLE : ISSUE;
    end
`ifdef DISPATCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic stall_q, stalled;
  assign stalled = in_issue && (pending & core_ready) == '0;
  // Counter saturates at the limit so a long stall cannot wrap it back to zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wd_cnt <= '0;
      stall_q <= 1'b0;
    end else begin
      wd_cnt <= flush || !stalled ? '0 : wd_cnt == CW'(TIMEOUT_CYCLES) ? wd_cnt : wd_cnt + 1'b1;
      stall_q <= !flush && (stall_q || (stalled && wd_cnt == CW'(TIMEOUT_CYCLES - 1)));
    end
  assign stall_timeout = stall_q;
`else
  assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_warp_issue_sequencer.sv
// tb_warp_issue_sequencer: directed and random checks of warp_issue_sequencer against a warp-level model.
module tb_warp_issue_sequencer;
  localparam int NW = 8, NT = 32, TO = 8, IW = 3;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [NW-1:0] warp_req = '0, warp_is_fp = '0, warp_grant;
  logic [NW*NT-1:0] warp_mask = '0;
  logic [NW*6-1:0] warp_opcode = '0;
  logic [NT-1:0] core_ready = '0, disp_thread_active;
  logic disp_warp_valid, disp_is_fp, issue_done, busy, stall_timeout;
  logic [5:0] disp_opcode;
  logic [IW-1:0] disp_warp_id, issue_done_id;
  always #5 clk = ~clk;
  warp_issue_sequencer #(.NUM_WARPS(NW), .NUM_THREADS(NT), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .warp_req(warp_req), .warp_mask(warp_mask),
    .warp_opcode(warp_opcode), .warp_is_fp(warp_is_fp), .core_ready(core_ready),
    .flush(flush), .warp_grant(warp_grant), .disp_warp_valid(disp_warp_valid),
    .disp_thread_active(disp_thread_active), .disp_opcode(disp_opcode),
    .disp_is_fp(disp_is_fp), .disp_warp_id(disp_warp_id), .issue_done(issue_done),
    .issue_done_id(issue_done_id), .busy(busy), .stall_timeout(stall_timeout)
  );
  int tests = 0, fails = 0;
  // Model: one warp in flight with its remaining threads, plus the last granted slot.
  bit m_busy, m_fp, m_stall;
  logic [NT-1:0] m_pend;
  logic [5:0] m_op;
  int m_slot, m_last, m_wd;
  logic [NW-1:0] seen_grant;
  logic [NT-1:0] seen_active;
  logic seen_done, seen_valid, seen_busy, seen_stall;
  logic [IW-1:0] seen_done_id;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int rr_pick(input logic [NW-1:0] req, input int last);
    for (int k = 1; k <= NW; k++) if (req[(last + k) % NW]) return (last + k) % NW;
    return -1;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_pend = '0; m_slot = 0; m_last = NW - 1;
    m_op = '0; m_fp = 0; m_wd = 0; m_stall = 0;
  endtask
  task automatic step();
    int g;
    logic [NT-1:0] msk;
    logic [NW-1:0] eg;
    logic ed;
    int eid;
    @(negedge clk);
    eg = '0; ed = 0; eid = 0; msk = '0; g = -1;
    if (!m_busy) begin
      if (!flush && warp_req != '0) begin
        g = rr_pick(warp_req, m_last);
        eg[g] = 1'b1;
        msk = warp_mask[g*NT +: NT];
        ed = msk == '0;
        eid = g;
      end
    end else begin
      ed = !flush && (m_pend & ~core_ready) == '0;
      eid = m_slot;
    end
    chk("grant", warp_grant, eg);
    chk("valid", disp_warp_valid, m_busy);
    chk("busy", busy, m_busy);
    chk("active", disp_thread_active, m_pend);
    chk("opcode", disp_opcode, m_op);
    chk("is_fp", disp_is_fp, m_fp);
    chk("warp_id", disp_warp_id, m_slot[IW-1:0]);
    chk("done", issue_done, ed);
    if (ed) chk("done_id", issue_done_id, eid[IW-1:0]);
    chk("stall", stall_timeout, m_stall);
    seen_grant = warp_grant; seen_active = disp_thread_active; seen_done = issue_done;
    seen_valid = disp_warp_valid; seen_busy = busy; seen_stall = stall_timeout;
    seen_done_id = issue_done_id;
    @(posedge clk);
`ifdef DISPATCH_WATCHDOG_EN
    if (flush) begin m_wd = 0; m_stall = 0; end
    else if (m_busy && (m_pend & core_ready) == '0) begin m_wd++; if (m_wd >= TO) m_stall = 1; end
    else m_wd = 0;
`endif
    if (!m_busy) begin
      if (g >= 0) begin
        m_last = g; m_slot = g; m_pend = msk;
        m_op = warp_opcode[g*6 +: 6]; m_fp = warp_is_fp[g];
        m_busy = msk != '0;
      end
    end else if (flush) begin
      m_pend = '0; m_busy = 0;
    end else begin
      m_pend = m_pend & ~core_ready;
      m_busy = m_pend != '0;
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_grant", warp_grant, '0);
    chk("rst_valid", disp_warp_valid, 0);
    chk("rst_active", disp_thread_active, '0);
    chk("rst_opcode", disp_opcode, '0);
    chk("rst_fp", disp_is_fp, 0);
    chk("rst_id", disp_warp_id, '0);
    chk("rst_done", issue_done, 0);
    chk("rst_done_id", issue_done_id, '0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall_timeout, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic set_slot(input int s, input logic [NT-1:0] m, input logic [5:0] op, input logic fp);
    warp_mask[s*NT +: NT] = m;
    warp_opcode[s*6 +: 6] = op;
    warp_is_fp[s] = fp;
  endtask
  initial begin
    logic [NW-1:0] rr_exp [8];
    logic [NW-1:0] fresh_req;
    rr_exp = '{8'h01, 8'h00, 8'h08, 8'h00, 8'h80, 8'h00, 8'h01, 8'h00};
    model_reset();
    warp_req = 8'h21;
    do_reset();
    // Round robin among slots 0, 3, 7
    for (int s = 0; s < NW; s++) set_slot(s, '1, 6'(s + 10), s[0]);
    core_ready = '1;
    warp_req = 8'b1000_1001;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rr_grant_%0d", k), seen_grant, rr_exp[k]);
    end
    warp_req = '0;
    step();
    // Single warp, all cores ready
    set_slot(2, 32'hFFFF_FFFF, 6'h2A, 1'b1);
    warp_req = 8'h04;
    step();
    chk("single_grant", seen_grant, 8'h04);
    warp_req = '0;
    step();
    chk("single_active", seen_active, 32'hFFFF_FFFF);
    chk("single_done", seen_done, 1);
    chk("single_done_id", seen_done_id, 3'd2);
    // Partial readiness replay
    set_slot(4, 32'h0000_00FF, 6'h11, 1'b0);
    warp_req = 8'h10;
    step();
    warp_req = '0;
    core_ready = 32'h0F;
    step();
    chk("partial_b1_active", seen_active, 32'hFF);
    chk("partial_b1_done", seen_done, 0);
    core_ready = 32'hF0;
    step();
    chk("partial_b2_active", seen_active, 32'hF0);
    chk("partial_b2_done", seen_done, 1);
    // Zero mask
    set_slot(5, '0, 6'h05, 1'b1);
    warp_req = 8'h20;
    step();
    chk("zero_grant", seen_grant, 8'h20);
    chk("zero_done", seen_done, 1);
    chk("zero_done_id", seen_done_id, 3'd5);
    chk("zero_valid", seen_valid, 0);
    warp_req = '0;
    step();
    chk("zero_idle", seen_busy, 0);
    // Flush in beat 2 of a 4-beat warp
    set_slot(1, 32'hF, 6'h33, 1'b0);
    warp_req = 8'h02;
    step();
    warp_req = '0;
    core_ready = 32'h1;
    step();
    core_ready = 32'h2;
    flush = 1'b1;
    step();
    chk("flush_done", seen_done, 0);
    chk("flush_beat_active", seen_active, 32'hE);
    flush = 1'b0;
    step();
    chk("flush_idle", seen_busy, 0);
    chk("flush_pending", seen_active, '0);
    // Reset mid-issue
    set_slot(6, 32'hFF, 6'h16, 1'b1);
    set_slot(0, 32'h3, 6'h01, 1'b0);
    core_ready = '0;
    warp_req = 8'h40;
    step();
    warp_req = 8'h41;
    step();
    do_reset();
    step();
    chk("post_rst_grant", seen_grant, 8'h01);
    warp_req = '0;
    core_ready = '1;
    step();
    // Watchdog stall
    set_slot(3, 32'h3, 6'h07, 1'b0);
    warp_req = 8'h08;
    step();
    warp_req = '0;
    core_ready = '0;
    for (int k = 0; k < 10; k++) step();
`ifdef DISPATCH_WATCHDOG_EN
    chk("wd_set", seen_stall, 1);
`else
    chk("wd_off", seen_stall, 0);
`endif
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("wd_cleared", seen_stall, 0);
    // Random traffic with requesters holding until granted
    fresh_req = '0;
    for (int c = 0; c < 400; c++) begin
      fresh_req = fresh_req | (8'($urandom) & 8'($urandom));
      for (int s = 0; s < NW; s++) begin
        int sel;
        sel = $urandom_range(0, 3);
        if (!fresh_req[s] || c % 5 == 0)
          set_slot(s, sel == 0 ? '0 : sel == 1 ? '1 : sel == 2 ? NT'($urandom) : NT'($urandom & $urandom),
                   6'($urandom), 1'($urandom));
      end
      warp_req = fresh_req;
      core_ready = $urandom_range(0, 1) ? '1 : NT'($urandom);
      flush = $urandom_range(0, 19) == 0;
      step();
      fresh_req = fresh_req & ~seen_grant;
    end
    flush = 1'b0;
    warp_req = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
